// File: rtl/mod_pow2_scale_seq_if.sv
// Handshake bundle for the modular power-of-two scaler: x in on valid/ready, z/err out on valid/ready.
// master drives x/in_valid/out_ready; slave (the scaler) drives the rest.
interface mod_pow2_scale_seq_if #(
  parameter int W = 6
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         busy;
  logic         err;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, z, busy, err
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, z, busy, err
  );
endinterface

// File: rtl/mod_pow2_scale_seq.sv
// z = (x * 2^K_EXP) mod M via K_EXP modular doublings; optional MOD_SCALE_RANGE_CHK_EN flags x >= M on err.
// Latency: out_valid K_EXP+1 cycles after x is presented; one result per K_EXP+2 cycles.
// Backpressure: in_ready low from accept until the result is taken; z/err held while out_ready is low.
module mod_pow2_scale_seq #(
  parameter int M     = 53,
  parameter int W     = 6,
  parameter int K_EXP = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_pow2_scale_seq_if.slave  s
);

  localparam int             CW       = (K_EXP > 0) ? $clog2(K_EXP + 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST = (K_EXP > 0) ? CW'(K_EXP - 1) : '0;
  localparam logic [W:0]     MOD      = (W + 1)'(M);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  r;
  logic [CW-1:0] cnt;
  logic [W:0]    dbl_d;
  logic [W-1:0]  dbl_r;
  logic          range_bad;

  // r < M keeps 2r < 2M, so one conditional subtract fully reduces it.
  always_comb begin
    dbl_d = {r, 1'b0};
    dbl_r = dbl_d[W-1:0];
    if (dbl_d >= MOD) begin
      dbl_r = W'(dbl_d - MOD);
    end
  end

`ifdef MOD_SCALE_RANGE_CHK_EN
  logic err_q;

  assign range_bad = ({1'b0, s.x} >= MOD);
  assign s.err     = err_q;
`else
  assign range_bad = 1'b0;
  assign s.err     = 1'b0;
`endif

  // All handshake outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s.in_ready  <= 1'b1;
      s.out_valid <= 1'b0;
      s.z         <= '0;
      s.busy      <= 1'b0;
      cnt         <= '0;
      r           <= '0;
`ifdef MOD_SCALE_RANGE_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s.in_valid) begin
            r          <= s.x;
            cnt        <= '0;
            s.in_ready <= 1'b0;
            s.busy     <= 1'b1;
`ifdef MOD_SCALE_RANGE_CHK_EN
            err_q      <= range_bad;
`endif
            if (range_bad) begin
              state       <= DONE;
              s.out_valid <= 1'b1;
              s.z         <= '0;
            end else if (K_EXP == 0) begin
              state       <= DONE;
              s.out_valid <= 1'b1;
              s.z         <= s.x;
            end else begin
              state <= BUSY;
            end
          end
        end

        BUSY: begin
          r   <= dbl_r;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state       <= DONE;
            s.out_valid <= 1'b1;
            s.z         <= dbl_r;
          end
        end

        DONE: begin
          if (s.out_ready) begin
            state       <= IDLE;
            s.out_valid <= 1'b0;
            s.in_ready  <= 1'b1;
            s.busy      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          s.in_ready  <= 1'b1;
          s.out_valid <= 1'b0;
          s.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_pow2_scale_seq.sv
// Scoreboard bench for mod_pow2_scale_seq: default build plus K_EXP=0 and M=97/W=7/K_EXP=10 instances.
module tb_mod_pow2_scale_seq;

  localparam int M_A = 53;
  localparam int K_A = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   acc_cyc = 0;

  typedef struct {
    longint z;
    longint err;
  } exp_t;

  exp_t exp_q[$];

  mod_pow2_scale_seq_if #(.W(6)) a ();
  mod_pow2_scale_seq_if #(.W(6)) k0 ();
  mod_pow2_scale_seq_if #(.W(7)) b ();

  mod_pow2_scale_seq #(.M(53), .W(6), .K_EXP(6)) dut_a (
    .clk (clk),
    .rst (rst),
    .s   (a)
  );

  mod_pow2_scale_seq #(.M(53), .W(6), .K_EXP(0)) dut_k0 (
    .clk (clk),
    .rst (rst),
    .s   (k0)
  );

  mod_pow2_scale_seq #(.M(97), .W(7), .K_EXP(10)) dut_b (
    .clk (clk),
    .rst (rst),
    .s   (b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint scale_ref(input longint xv, input longint m, input int k);
    return (xv * (longint'(1) << k)) % m;
  endfunction

  function automatic exp_t expect_a(input int v);
    exp_t e;
`ifdef MOD_SCALE_RANGE_CHK_EN
    if (v >= M_A) begin
      e.z   = 0;
      e.err = 1;
      return e;
    end
`endif
    e.z   = scale_ref(v, M_A, K_A);
    e.err = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && a.out_valid && a.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("z", a.z, e.z);
        chk("err", a.err, e.err);
      end
    end
  end

  task automatic send_a(input int v, input bit chk_gap);
    bit ok = 1'b0;
    int prev = acc_cyc;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (a.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    a.in_valid = 1'b1;
    a.x        = 6'(v);
    exp_q.push_back(expect_a(v));
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    a.in_valid = 1'b0;
    if (chk_gap) chk("accept_gap", acc_cyc - prev, K_A + 2);
    @(negedge clk);
    chk("in_ready_low", a.in_ready, 0);
  endtask

  task automatic wait_out_a(output int lat);
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      if (a.out_valid) begin
        lat = cyc - acc_cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic drain;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    chk("watchdog", 0, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "bench timed out");
  end

  initial begin
    int lat;
    int n;
    a.in_valid  = 1'b0;
    a.x         = '0;
    a.out_ready = 1'b1;
    k0.in_valid = 1'b0;
    k0.x        = '0;
    k0.out_ready = 1'b1;
    b.in_valid  = 1'b0;
    b.x         = '0;
    b.out_ready = 1'b1;

    // reset values
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", a.in_ready, 1);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_z", a.z, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_err", a.err, 0);

    // single operation and its latency
    send_a(1, 1'b0);
    chk("busy_after_accept", a.busy, 1);
    wait_out_a(lat);
    chk("latency", lat, K_A + 1);
    drain();

    // full residue sweep, back to back
    for (int v = 0; v < M_A; v++) send_a(v, v > 0);
    drain();

    // hold the result with downstream stalled and upstream pushing
    a.out_ready = 1'b0;
    send_a(10, 1'b0);
    wait_out_a(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", a.out_valid, 1);
      chk("hold_z", a.z, scale_ref(10, M_A, K_A));
      chk("hold_in_ready", a.in_ready, 0);
      a.in_valid = 1'b1;
      a.x        = 6'(i * 5);
    end
    @(posedge clk);
    #1;
    a.in_valid  = 1'b0;
    a.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", a.in_ready, 1);
    chk("release_busy", a.busy, 0);
    chk("release_out_valid", a.out_valid, 0);
    chk("hold_no_accept", exp_q.size(), 0);

    // reset mid-operation at cnt==3
    send_a(7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", a.in_ready, 1);
    chk("midrst_out_valid", a.out_valid, 0);
    chk("midrst_busy", a.busy, 0);
    chk("midrst_z", a.z, 0);
    chk("midrst_err", a.err, 0);
    send_a(33, 1'b0);
    drain();

`ifdef MOD_SCALE_RANGE_CHK_EN
    // out-of-range input bypasses the doublings
    send_a(60, 1'b0);
    wait_out_a(lat);
    chk("range_latency", lat, 1);
    drain();
    send_a(2, 1'b0);
    drain();
`endif

    // K_EXP=0 instance
    @(negedge clk);
    chk("k0_in_ready", k0.in_ready, 1);
    k0.in_valid = 1'b1;
    k0.x        = 6'd17;
    @(posedge clk);
    #1 k0.in_valid = 1'b0;
    @(negedge clk);
    chk("k0_valid", k0.out_valid, 1);
    chk("k0_z", k0.z, scale_ref(17, 53, 0));
    chk("k0_err", k0.err, 0);

    // M=97, W=7, K_EXP=10 instance
    @(negedge clk);
    b.in_valid = 1'b1;
    b.x        = 7'd5;
    @(posedge clk);
    #1 b.in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!b.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("m97_latency", n, 11);
    chk("m97_z", b.z, scale_ref(5, 97, 10));
    chk("m97_err", b.err, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
